bf_decode_fold: RTL and testbench
=================================

Name: bf_decode_fold

Overview:
- Next-generation instruction decoder for the bfX core.
- Decodes a valid/ready stream of 8-bit instruction bytes into the five op classes plus a mode bit.
- Run-length folds consecutive identical pointer-move and data ops into one op carrying a repeat count.
- Drops undefined opcodes and halts intake at STOP.
- Sits between instruction fetch and the execute stage; the repeat count lets execute apply one op N times in a single operation.

Parameters:
COUNT_W, 8, width of repeat count; maximum fold = 2^COUNT_W-1
FOLD_EN, 1, 1 = folding enabled; 0 = every emitted op has count 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ix  in  8  instruction byte
in_valid  in  1  ix valid
in_ready  out  1  block accepts ix this cycle
flush  in  1  force emission of pending folded op (upstream fetch idle or branch)
out_valid  out  1  decoded op valid
out_ready  in  1  downstream accepts op
out_dc  out  1  pointer-move op
out_data  out  1  data inc/dec op
out_io  out  1  io op
out_branch  out  1  branch op
out_stop  out  1  stop op
out_mode  out  1  ix[0] of op
out_count  out  COUNT_W  repeat count, >=1
halted  out  1  STOP has been delivered downstream

Behaviour:
- One clock domain (clk); reset is synchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Class decode:
  - dc when ix[3:1]=000; data when 001; io when 010; branch when 100; stop when ix=8'hFF.
  - Every other byte is NOP: consumed, never emitted, and does not break a run.
- Foldable ops are dc and data, and only when FOLD_EN=1.
- Storage: one accumulator (acc_valid, acc_ix, acc_cnt) feeding one output register. out_* fields are registered.
- out_free = !out_valid | out_ready.
- in_ready = !stop_seen & !(out_valid & !out_ready). It is combinational from registered state and out_ready.
- Per-cycle rules, on an accepted byte b:
  - If b is NOP: no change.
  - If b is foldable, acc_valid=1, acc_ix==b and acc_cnt<MAX: acc_cnt+1.
  - Otherwise: if acc_valid, the acc contents move to the output register; then acc <= {b, 1}.
- Non-foldable acc (io/branch/stop, or any op with FOLD_EN=0) moves to the output register in the first cycle it is not already moving and out_free=1.
- If flush=1 and no byte is accepted in that cycle: acc (any class) moves to the output when out_free; otherwise it is held.
- Saturation: at acc_cnt=MAX, a further identical byte emits the current acc and restarts the acc at count 1.
- Latency, idle block, out_ready=1, byte accepted in cycle N:
  - Non-foldable op: out_valid in cycle N+2.
  - Foldable op: out_valid 1 cycle after the terminating byte, flush, or saturation.
- Output stability: while out_valid & !out_ready, all out_* fields hold stable.
- Emission order always equals acceptance order.
- STOP handling:
  - Accepting 8'hFF sets stop_seen; in_ready=0 from the next cycle.
  - The pending acc is emitted, then STOP with count 1.
  - halted=1 from the cycle after the STOP handshake (out_valid & out_ready & out_stop).
  - Only reset clears halted and stop_seen.
- Reset values (rst_n=0 sampled at a clk edge, including mid-run or mid-backpressure): all out_* = 0, out_count = 0, acc_valid = 0, stop_seen = 0, halted = 0. Pending ops are discarded.
- Exactly one class flag is high whenever out_valid=1; all flags are 0 when out_valid=0.

Test Plan:
- Stream 02,02,02,04, out_ready=1 -> (data,m0,cnt3) then (io,m0,cnt1); no other outputs.
- COUNT_W=2: 00 x5 then flush=1 -> (dc,m0,3), (dc,m0,2).
- out_ready=0, stream 08,09 -> out_valid with (branch,m0,1) held stable and in_ready=0 while stalled; release -> (branch,m0,1) then (branch,m1,1), in order.
- Stream 03,06,0E,03, flush -> single (data,m1,cnt2); NOP bytes 06 and 0E neither emitted nor breaking the run.
- Stream 00,01,FF,02 -> (dc,m0,1),(dc,m1,1),(stop,1); halted=1 afterwards; 02 never accepted; one-cycle rst_n=0 -> halted=0, in_ready=1.
- FOLD_EN=0: 02,02 -> two (data,m0,1) outputs. Also: rst_n=0 during a fold of 3x 00 -> no output after reset.

Source files
------------

// File: rtl/bf_decode_fold_if.sv
// bf_decode_fold_if: instruction-byte stream in, decoded op stream out.
// Ports (signals): ix/in_valid/in_ready byte stream, flush request,
// out_valid/out_ready op stream with class flags, mode bit, repeat count,
// and halted status. master = fetch/execute side, slave = decoder.
interface bf_decode_fold_if #(parameter int COUNT_W = 8);
  logic [7:0] ix;
  logic in_valid;
  logic in_ready;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic out_dc;
  logic out_data;
  logic out_io;
  logic out_branch;
  logic out_stop;
  logic out_mode;
  logic [COUNT_W-1:0] out_count;
  logic halted;
  modport master (
    output ix, in_valid, flush, out_ready,
    input in_ready, out_valid, out_dc, out_data, out_io, out_branch, out_stop, out_mode, out_count, halted
  );
  modport slave (
    input ix, in_valid, flush, out_ready,
    output in_ready, out_valid, out_dc, out_data, out_io, out_branch, out_stop, out_mode, out_count, halted
  );
endinterface

// File: rtl/bf_decode_fold.sv
// bf_decode_fold: decodes instruction bytes into op classes and run-length folds dc/data ops.
// Ports: clk, rst_n (sync active-low), bus (slave modport of bf_decode_fold_if).
// One accumulator (op being folded) feeds one registered output stage.
module bf_decode_fold #(
  parameter int COUNT_W = 8,
  parameter bit FOLD_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bf_decode_fold_if.slave bus
);
  localparam logic [COUNT_W-1:0] MAX = '1;
  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);
  // class vector order: {dc, data, io, branch, stop}; all-zero means NOP
  function automatic logic [4:0] cls(input logic [7:0] b);
    return {b[3:1] == 3'b000, b[3:1] == 3'b001, b[3:1] == 3'b010, b[3:1] == 3'b100, b == 8'hFF};
  endfunction
  // dc and data are exactly the bytes with ix[3:2] == 00
  function automatic logic foldable(input logic [7:0] b);
    return FOLD_EN && (b[3:2] == 2'b00);
  endfunction
  logic r_acc_v;
  logic [7:0] r_acc_ix;
  logic [COUNT_W-1:0] r_acc_cnt;
  logic r_stop_seen;
  logic r_halted;
  logic r_out_v;
  logic [4:0] r_out_cls;
  logic r_out_mode;
  logic [COUNT_W-1:0] r_out_cnt;
  logic w_free;
  logic w_in_ready;
  logic w_acc;
  logic w_nop;
  logic w_fold;
  logic w_load;
  logic w_move;
  assign w_free = !r_out_v || bus.out_ready;
  assign w_in_ready = !r_stop_seen && w_free;
  assign w_acc = bus.in_valid && w_in_ready;
  assign w_nop = cls(bus.ix) == '0;
  assign w_fold = w_acc && !w_nop && foldable(bus.ix) && r_acc_v && r_acc_ix == bus.ix && r_acc_cnt != MAX;
  assign w_load = w_acc && !w_nop && !w_fold;
  // a new op displaces the acc; non-foldable ops leave as soon as possible;
  // flush only drains when no byte arrives in the same cycle
  assign w_move = r_acc_v && w_free && (w_load || !foldable(r_acc_ix) || (bus.flush && !w_acc));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_v <= 1'b0;
      r_acc_ix <= '0;
      r_acc_cnt <= '0;
      r_stop_seen <= 1'b0;
      r_halted <= 1'b0;
      r_out_v <= 1'b0;
      r_out_cls <= '0;
      r_out_mode <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      if (w_load) begin
        r_acc_v <= 1'b1;
        r_acc_ix <= bus.ix;
        r_acc_cnt <= ONE;
      end else if (w_fold) r_acc_cnt <= r_acc_cnt + ONE;
      else if (w_move) r_acc_v <= 1'b0;
      if (w_move) begin
        r_out_v <= 1'b1;
        r_out_cls <= cls(r_acc_ix);
        r_out_mode <= r_acc_ix[0];
        r_out_cnt <= r_acc_cnt;
      end else if (bus.out_ready) begin
        r_out_v <= 1'b0;
        r_out_cls <= '0;
        r_out_mode <= 1'b0;
        r_out_cnt <= '0;
      end
      if (w_acc && bus.ix == 8'hFF) r_stop_seen <= 1'b1;
      if (r_out_v && bus.out_ready && r_out_cls[0]) r_halted <= 1'b1;
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = r_out_v;
  assign {bus.out_dc, bus.out_data, bus.out_io, bus.out_branch, bus.out_stop} = r_out_cls;
  assign bus.out_mode = r_out_mode;
  assign bus.out_count = r_out_cnt;
  assign bus.halted = r_halted;
endmodule

// File: tb/tb_bf_decode_fold.sv
// tb_bf_decode_fold: directed checks of bf_decode_fold (default, COUNT_W=2, FOLD_EN=0 instances).
module tb_bf_decode_fold;
  localparam logic [4:0] C_DC = 5'b10000;
  localparam logic [4:0] C_DA = 5'b01000;
  localparam logic [4:0] C_IO = 5'b00100;
  localparam logic [4:0] C_BR = 5'b00010;
  localparam logic [4:0] C_ST = 5'b00001;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  bf_decode_fold_if #(.COUNT_W(8)) if0();
  bf_decode_fold_if #(.COUNT_W(2)) if1();
  bf_decode_fold_if #(.COUNT_W(8)) if2();
  bf_decode_fold #(.COUNT_W(8), .FOLD_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bf_decode_fold #(.COUNT_W(2), .FOLD_EN(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bf_decode_fold #(.COUNT_W(8), .FOLD_EN(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  logic [7:0] t_ix[3];
  logic t_iv[3];
  logic t_fl[3];
  logic t_or[3];
  logic t_irdy[3];
  logic t_ov[3];
  logic t_halt[3];
  logic [13:0] t_rec[3];
  assign if0.ix = t_ix[0];
  assign if1.ix = t_ix[1];
  assign if2.ix = t_ix[2];
  assign if0.in_valid = t_iv[0];
  assign if1.in_valid = t_iv[1];
  assign if2.in_valid = t_iv[2];
  assign if0.flush = t_fl[0];
  assign if1.flush = t_fl[1];
  assign if2.flush = t_fl[2];
  assign if0.out_ready = t_or[0];
  assign if1.out_ready = t_or[1];
  assign if2.out_ready = t_or[2];
  assign t_irdy[0] = if0.in_ready;
  assign t_irdy[1] = if1.in_ready;
  assign t_irdy[2] = if2.in_ready;
  assign t_ov[0] = if0.out_valid;
  assign t_ov[1] = if1.out_valid;
  assign t_ov[2] = if2.out_valid;
  assign t_halt[0] = if0.halted;
  assign t_halt[1] = if1.halted;
  assign t_halt[2] = if2.halted;
  assign t_rec[0] = {if0.out_dc, if0.out_data, if0.out_io, if0.out_branch, if0.out_stop, if0.out_mode, if0.out_count};
  assign t_rec[1] = {if1.out_dc, if1.out_data, if1.out_io, if1.out_branch, if1.out_stop, if1.out_mode, 6'd0, if1.out_count};
  assign t_rec[2] = {if2.out_dc, if2.out_data, if2.out_io, if2.out_branch, if2.out_stop, if2.out_mode, if2.out_count};
  logic [15:0] q[$];
  int n_chk = 0;
  int n_fail = 0;
  always @(negedge clk)
    for (int d = 0; d < 3; d++)
      if (rst_n && t_ov[d] && t_or[d]) q.push_back({2'(d), t_rec[d]});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input logic [7:0] b);
    int n;
    n = 0;
    t_ix[d] = b;
    t_iv[d] = 1'b1;
    @(negedge clk);
    while (!t_irdy[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!t_irdy[d]) chk("send_timeout", 32'(t_irdy[d]), 1);
    @(posedge clk);
    #1;
    t_iv[d] = 1'b0;
  endtask
  task automatic flush_pulse(input int d);
    t_fl[d] = 1'b1;
    tick();
    t_fl[d] = 1'b0;
  endtask
  task automatic exp_op(input string tag, input int d, input logic [4:0] c, input logic m, input int cnt);
    int n;
    n = 0;
    while (q.size() == 0 && n < 50) begin
      n++;
      tick();
    end
    if (q.size() == 0) chk({tag, "_timeout"}, 32'(q.size()), 1);
    else chk(tag, 32'(q.pop_front()), 32'({2'(d), c, m, 8'(cnt)}));
  endtask
  task automatic exp_none(input string tag);
    repeat (8) tick();
    chk(tag, 32'(q.size()), 0);
    q.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      t_ix[d] = 8'h00;
      t_iv[d] = 1'b0;
      t_fl[d] = 1'b0;
      t_or[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(t_ov[0]), 0);
    chk("rst_fields", 32'(t_rec[0]), 0);
    chk("rst_in_ready", 32'(t_irdy[0]), 1);
    chk("rst_halted", 32'(t_halt[0]), 0);
    send(0, 8'h02);
    send(0, 8'h02);
    send(0, 8'h02);
    send(0, 8'h04);
    exp_op("fold_data3", 0, C_DA, 1'b0, 3);
    exp_op("io_after_run", 0, C_IO, 1'b0, 1);
    exp_none("fold_no_extra");
    repeat (5) send(1, 8'h00);
    flush_pulse(1);
    exp_op("sat_dc3", 1, C_DC, 1'b0, 3);
    exp_op("sat_dc2", 1, C_DC, 1'b0, 2);
    exp_none("sat_no_extra");
    t_or[0] = 1'b0;
    send(0, 8'h08);
    send(0, 8'h09);
    repeat (3) tick();
    chk("bp_valid", 32'(t_ov[0]), 1);
    chk("bp_in_ready", 32'(t_irdy[0]), 0);
    chk("bp_fields", 32'(t_rec[0]), 32'({C_BR, 1'b0, 8'd1}));
    repeat (2) tick();
    chk("bp_hold", 32'(t_rec[0]), 32'({C_BR, 1'b0, 8'd1}));
    chk("bp_no_handshake", 32'(q.size()), 0);
    t_or[0] = 1'b1;
    exp_op("bp_br_m0", 0, C_BR, 1'b0, 1);
    exp_op("bp_br_m1", 0, C_BR, 1'b1, 1);
    exp_none("bp_no_extra");
    send(0, 8'h03);
    send(0, 8'h06);
    send(0, 8'h0E);
    send(0, 8'h03);
    flush_pulse(0);
    exp_op("nop_fold", 0, C_DA, 1'b1, 2);
    exp_none("nop_no_extra");
    send(0, 8'h00);
    send(0, 8'h01);
    send(0, 8'hFF);
    t_ix[0] = 8'h02;
    t_iv[0] = 1'b1;
    exp_op("stop_dc_m0", 0, C_DC, 1'b0, 1);
    exp_op("stop_dc_m1", 0, C_DC, 1'b1, 1);
    exp_op("stop_op", 0, C_ST, 1'b1, 1);
    n = 0;
    while (!t_halt[0] && n < 20) begin
      n++;
      tick();
    end
    chk("stop_halted", 32'(t_halt[0]), 1);
    chk("stop_in_ready", 32'(t_irdy[0]), 0);
    exp_none("stop_no_extra");
    t_iv[0] = 1'b0;
    chk("stop_halted_hold", 32'(t_halt[0]), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_halted", 32'(t_halt[0]), 0);
    chk("rst2_in_ready", 32'(t_irdy[0]), 1);
    send(2, 8'h02);
    send(2, 8'h02);
    exp_op("nofold_a", 2, C_DA, 1'b0, 1);
    exp_op("nofold_b", 2, C_DA, 1'b0, 1);
    exp_none("nofold_no_extra");
    repeat (3) send(0, 8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    flush_pulse(0);
    exp_none("rst_discard");
    chk("rst_discard_valid", 32'(t_ov[0]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
